mc_control: RTL and testbench
=============================

// Module: mc_control
// PURPOSE
//  Multicycle ARM control unit; successor to the single-cycle decoder. Moore FSM sequences
//  fetch/decode/execute/writeback over one shared memory port, with a memory-ready wait
//  handshake. Adds CMP/TST decode (NoWrite) and a defined Undef pulse. Drives datapath
//  muxes/enables; RegW/MemW/PCS/FlagW go to the existing conditional-logic block for gating.
// PARAMETERS
//  ALUCTL_W      3  ALUControl width (>=3); upper bits zero-filled
//  MEM_HANDSHAKE 1  1: memory states wait for MemReady; 0: MemReady treated as constant 1
//  MUL_CYCLES    4  multiply latency in MULWAIT cycles (>=1); used only with ARM_MUL_EN
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-low reset
//  Op         in   2  Instr[27:26]
//  Funct      in   6  Instr[25:20] (I, cmd[3:0], S)
//  Rd         in   4  Instr[15:12]
//  IsMul      in   1  Instr[7:4]==4'b1001; ignored without ARM_MUL_EN
//  MemReady   in   1  memory completes the current access this cycle
//  IRWrite    out  1  load instruction register
//  NextPC     out  1  PC <- PC+4
//  AdrSrc     out  1  0: PC, 1: ALU result as memory address
//  ALUSrcA    out  1  0: register A, 1: PC
//  ALUSrcB    out  2  00: reg B, 01: ExtImm, 10: const 4
//  ResultSrc  out  2  00: ALUOut, 01: ReadData, 10: ALU result
//  ImmSrc     out  2  = Op (00 data-proc, 01 memory, 10 branch)
//  RegSrc     out  2  {Op==10, Op==01}
//  ALUControl out  ALUCTL_W  ADD 0, SUB 1, AND 2, ORR 3, EOR 4, MUL 5
//  FlagW      out  2  [1]=NZ, [0]=CV write enables
//  RegW       out  1  register write (pre-condition)
//  MemW       out  1  memory write (pre-condition)
//  PCS        out  1  ((Rd==15) & RegW) | Branch
//  Undef      out  1  1-cycle pulse: undefined instruction seen in DECODE
//  MulBusy    out  1  high in MULWAIT; 0 without ARM_MUL_EN
// BEHAVIOUR
//  - Reset: state <= FETCH, mul counter <= 0. While reset low, IRWrite, NextPC, RegW, MemW,
//    PCS, Undef, MulBusy = 0; other outputs take FETCH values. Reset mid-instruction aborts it.
//  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, MULWAIT.
//  - FETCH: AdrSrc 0, ALUSrcA 1, ALUSrcB 10, ResultSrc 10, ADD. IRWrite = NextPC = MemReady.
//    Stays in FETCH until MemReady, then DECODE.
//  - DECODE: ALUSrcA 1, ALUSrcB 10, ResultSrc 10 (R15 = PC+8). Next state:
//    Op 01 -> MEMADR; Op 00 & Funct[5] -> EXECI; Op 00 & ~Funct[5] -> EXECR;
//    Op 10 -> BRANCH; Op 11 or unsupported cmd -> Undef=1, next FETCH.
//  - MEMADR: ALUSrcA 0, ALUSrcB 01, ADD; Funct[0] ? MEMRD : MEMWR.
//  - MEMRD: AdrSrc 1; wait for MemReady, then MEMWB. MEMWB: ResultSrc 01, RegW 1 -> FETCH.
//  - MEMWR: AdrSrc 1, MemW 1 (every wait cycle); FETCH once MemReady.
//  - EXECR: ALUSrcB 00; EXECI: ALUSrcB 01; both ALUSrcA 0, ALUOp active -> ALUWB.
//  - ALUWB: ResultSrc 00, RegW = ~NoWrite -> FETCH. BRANCH: ALUSrcB 01, ResultSrc 10,
//    Branch 1 -> FETCH.
//  - ALUOp cmd map: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1010 CMP (SUB, NoWrite),
//    1000 TST (AND, NoWrite); any other -> Undef. ALUOp inactive: ALUControl = ADD, FlagW 00.
//  - FlagW[1] = S; FlagW[0] = S & (ADD|SUB|CMP); asserted only in EXECR/EXECI.
//  - Latency (MemReady=1): data-proc/load 4/5 cycles, store 4, branch 3.
//  - Simultaneous events: MemReady is ignored outside FETCH/MEMRD/MEMWR. MEM_HANDSHAKE=0 removes
//    all wait cycles.
// CONFIGURATION
//  ARM_MUL_EN defined: in EXECR, Op 00 & cmd 0000 & IsMul -> MULWAIT. Counter loads
//  MUL_CYCLES-1 on entry; ALUControl=MUL, MulBusy=1 in MULWAIT; at count 0 -> ALUWB.
//  Undefined: IsMul ignored (decodes as AND), no MULWAIT, MulBusy tied 0.
// TESTING
//  - reset low mid-MEMWR -> MemW 0 at once; release -> FETCH, IRWrite=1 on first MemReady.
//  - ADD R1 (Op00,Funct 001000), MemReady=1 -> FETCH,DECODE,EXECR,ALUWB; RegW 1 in cycle 4.
//  - LDR, MemReady low 3 cycles in MEMRD -> held 3 cycles, then MEMWB with RegW 1, ResultSrc 01.
//  - CMP (Funct 010101) -> ALUControl 001, FlagW 11 in EXECR, RegW 0 in ALUWB.
//  - Op 11 -> Undef pulse 1 cycle in DECODE, next FETCH; MOV-unsupported cmd 1101 -> same.
//  - ARM_MUL_EN, MUL_CYCLES=4, MUL -> MulBusy 4 cycles, ALUControl 101, then ALUWB.

Source files
------------

// File: rtl/mc_control_if.sv
// Purpose: instruction-field / memory-ready inputs and datapath control outputs of mc_control.
// Latency: none; plain wires between the datapath and the control unit.
// Backpressure: MemReady is the only stall source, driven by the memory side.
//
// Ports (members):
//   Op, Funct, Rd, IsMul   instruction fields from the instruction register
//   MemReady               memory completes the current access this cycle
//   IRWrite .. MulBusy     control outputs (see mc_control header)
// Modports: master = datapath/memory side, slave = control unit.
interface mc_control_if #(
   parameter int ALUCTL_W = 3
);
   logic [1:0]          Op;
   logic [5:0]          Funct;
   logic [3:0]          Rd;
   logic                IsMul;
   logic                MemReady;

   logic                IRWrite;
   logic                NextPC;
   logic                AdrSrc;
   logic                ALUSrcA;
   logic [1:0]          ALUSrcB;
   logic [1:0]          ResultSrc;
   logic [1:0]          ImmSrc;
   logic [1:0]          RegSrc;
   logic [ALUCTL_W-1:0] ALUControl;
   logic [1:0]          FlagW;
   logic                RegW;
   logic                MemW;
   logic                PCS;
   logic                Undef;
   logic                MulBusy;

   modport master (
      output Op, Funct, Rd, IsMul, MemReady,
      input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
             ALUControl, FlagW, RegW, MemW, PCS, Undef, MulBusy
   );

   modport slave (
      input  Op, Funct, Rd, IsMul, MemReady,
      output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
             ALUControl, FlagW, RegW, MemW, PCS, Undef, MulBusy
   );
endinterface

// File: rtl/mc_control.sv
// Purpose: multicycle ARM control unit, Moore FSM over one shared memory port.
// Latency: data-proc 4, load 5, store 4, branch 3 cycles with memory always ready.
// Backpressure: FETCH/MEMRD/MEMWR hold until MemReady (unless MEM_HANDSHAKE=0).
//
// Ports: clk (rising edge), reset (async, active-low), bus (mc_control_if.slave):
//   inputs Op/Funct/Rd/IsMul/MemReady, outputs datapath mux selects and enables.
// Optional feature macro ARM_MUL_EN: adds the MULWAIT multiply state and counter.
// States not listed for a mux leave it at 0 (AdrSrc PC, SrcA reg A, SrcB reg B, ALUOut).
module mc_control #(
   parameter int ALUCTL_W      = 3,
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter int MUL_CYCLES    = 4
) (
   input  logic         clk,
   input  logic         reset,
   mc_control_if.slave  bus
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXECR, EXECI, ALUWB, BRANCH, MULWAIT
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_ORR = 3'd3;
   localparam logic [2:0] ALU_EOR = 3'd4;
   localparam logic [2:0] ALU_MUL = 3'd5;

   state_t     state_q, state_d;
   logic       mem_rdy;
   logic [3:0] cmd;
   logic [2:0] dec_alu;
   logic       no_write;
   logic       cmd_bad;
   logic       flag_cv;
   logic       undef_dec;
   logic       is_mul;
   logic       mul_done;

   // With the handshake disabled every memory access completes in one cycle.
   assign mem_rdy = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

   // Data-processing command decode; only meaningful for Op 00.
   always_comb begin
      cmd      = bus.Funct[4:1];
      dec_alu  = ALU_ADD;
      no_write = 1'b0;
      cmd_bad  = 1'b0;
      flag_cv  = 1'b0;
      case (cmd)
         4'b0100: begin dec_alu = ALU_ADD; flag_cv = 1'b1; end
         4'b0010: begin dec_alu = ALU_SUB; flag_cv = 1'b1; end
         4'b0000: dec_alu = ALU_AND;
         4'b1100: dec_alu = ALU_ORR;
         4'b0001: dec_alu = ALU_EOR;
         4'b1010: begin dec_alu = ALU_SUB; flag_cv = 1'b1; no_write = 1'b1; end
         4'b1000: begin dec_alu = ALU_AND; no_write = 1'b1; end
         default: cmd_bad = 1'b1;
      endcase
      undef_dec = (bus.Op == 2'b11) | ((bus.Op == 2'b00) & cmd_bad);
   end

`ifdef ARM_MUL_EN
   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;

   assign is_mul   = (bus.Op == 2'b00) & (cmd == 4'b0000) & bus.IsMul;
   assign mul_done = (mul_cnt_q == '0);

   // Loaded on entry so MULWAIT lasts exactly MUL_CYCLES cycles.
   always_comb begin
      mul_cnt_d = mul_cnt_q;
      if ((state_q == EXECR) && (state_d == MULWAIT))
         mul_cnt_d = CNT_W'(MUL_CYCLES - 1);
      else if ((state_q == MULWAIT) && !mul_done)
         mul_cnt_d = mul_cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) mul_cnt_q <= '0;
      else        mul_cnt_q <= mul_cnt_d;
   end
`else
   logic unused_mul;

   // Without the multiplier IsMul is ignored: the instruction decodes as AND.
   assign is_mul     = 1'b0;
   assign mul_done   = 1'b1;
   assign unused_mul = bus.IsMul ^ (MUL_CYCLES > 1);
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   if (mem_rdy) state_d = DECODE;
         DECODE: begin
            if (undef_dec)              state_d = FETCH;
            else if (bus.Op == 2'b01)   state_d = MEMADR;
            else if (bus.Op == 2'b10)   state_d = BRANCH;
            else if (bus.Funct[5])      state_d = EXECI;
            else                        state_d = EXECR;
         end
         MEMADR:  state_d = bus.Funct[0] ? MEMRD : MEMWR;
         MEMRD:   if (mem_rdy) state_d = MEMWB;
         MEMWB:   state_d = FETCH;
         MEMWR:   if (mem_rdy) state_d = FETCH;
         EXECR:   state_d = is_mul ? MULWAIT : ALUWB;
         EXECI:   state_d = ALUWB;
         ALUWB:   state_d = FETCH;
         BRANCH:  state_d = FETCH;
         MULWAIT: if (mul_done) state_d = ALUWB;
         default: state_d = FETCH;
      endcase
   end

   // Output logic
   always_comb begin
      logic [2:0] alu3;
      logic       regw;
      logic       branch;

      alu3          = ALU_ADD;
      regw          = 1'b0;
      branch        = 1'b0;
      bus.IRWrite   = 1'b0;
      bus.NextPC    = 1'b0;
      bus.AdrSrc    = 1'b0;
      bus.ALUSrcA   = 1'b0;
      bus.ALUSrcB   = 2'b00;
      bus.ResultSrc = 2'b00;
      bus.FlagW     = 2'b00;
      bus.MemW      = 1'b0;
      bus.Undef     = 1'b0;
      bus.MulBusy   = 1'b0;
      bus.ImmSrc    = bus.Op;
      bus.RegSrc    = {bus.Op == 2'b10, bus.Op == 2'b01};

      case (state_q)
         FETCH: begin
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            bus.IRWrite   = mem_rdy;
            bus.NextPC    = mem_rdy;
         end
         DECODE: begin
            // PC+4 again here gives R15 = PC+8 for operand reads.
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            bus.Undef     = undef_dec;
         end
         MEMADR:  bus.ALUSrcB = 2'b01;
         MEMRD:   bus.AdrSrc  = 1'b1;
         MEMWB: begin
            bus.ResultSrc = 2'b01;
            regw          = 1'b1;
         end
         MEMWR: begin
            bus.AdrSrc = 1'b1;
            bus.MemW   = 1'b1;
         end
         EXECR, EXECI: begin
            bus.ALUSrcB = (state_q == EXECI) ? 2'b01 : 2'b00;
            alu3        = dec_alu;
            bus.FlagW   = {bus.Funct[0], bus.Funct[0] & flag_cv};
         end
         ALUWB:   regw = ~no_write;
         BRANCH: begin
            bus.ALUSrcB   = 2'b01;
            bus.ResultSrc = 2'b10;
            branch        = 1'b1;
         end
         MULWAIT: begin
            alu3        = ALU_MUL;
            bus.MulBusy = 1'b1;
         end
         default: ;
      endcase

      bus.RegW = regw;
      bus.PCS  = ((bus.Rd == 4'hF) & regw) | branch;

      // Strobes are forced low while reset is held; muxes already sit at FETCH values.
      if (!reset) begin
         bus.IRWrite = 1'b0;
         bus.NextPC  = 1'b0;
         bus.RegW    = 1'b0;
         bus.MemW    = 1'b0;
         bus.PCS     = 1'b0;
         bus.Undef   = 1'b0;
         bus.MulBusy = 1'b0;
      end

      bus.ALUControl      = '0;
      bus.ALUControl[2:0] = alu3;
   end

endmodule

// File: tb/tb_mc_control.sv
// Purpose: self-checking bench for mc_control; per-cycle expected outputs queued as stimulus is planned.
// Latency: each queued entry corresponds to exactly one clock cycle of the DUT.
// Backpressure: MemReady is part of each queued entry, so stalls are scripted per cycle.
module tb_mc_control;
   localparam int W = 3;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mc_control_if #(.ALUCTL_W(W)) bus ();

   mc_control #(.ALUCTL_W(W), .MEM_HANDSHAKE(1'b1), .MUL_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        mr;
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  rd;
      logic        ismul;
      logic [17:0] exp;
      string       tag;
   } sb_t;

   sb_t sb[$];
   int  n_chk  = 0;
   int  n_pass = 0;

   logic [1:0] cur_op;
   logic [5:0] cur_funct;
   logic [3:0] cur_rd;
   logic       cur_ismul;

   // {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW, RegW, MemW, PCS, Undef, MulBusy}
   function automatic logic [17:0] observed();
      return {bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
              bus.ALUControl[2:0], bus.FlagW, bus.RegW, bus.MemW, bus.PCS, bus.Undef, bus.MulBusy};
   endfunction

   function automatic logic [17:0] mk(input logic irw, input logic npc, input logic adr,
                                      input logic sa, input logic [1:0] sbv, input logic [1:0] rs,
                                      input logic [2:0] alu, input logic [1:0] fw, input logic rw,
                                      input logic mw, input logic pcs, input logic ud, input logic mb);
      return {irw, npc, adr, sa, sbv, rs, alu, fw, rw, mw, pcs, ud, mb};
   endfunction

   function automatic logic [17:0] e_fetch(input logic mr);
      return mk(mr, mr, 1'b0, 1'b1, 2'b10, 2'b10, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_decode(input logic ud);
      return mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, ud, 1'b0);
   endfunction
   function automatic logic [17:0] e_memadr();
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_memrd();
      return mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_memwb(input logic pcs);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 3'd0, 2'b00, 1'b1, 1'b0, pcs, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_memwr();
      return mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_exec(input logic imm, input logic [2:0] alu, input logic [1:0] fw);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, imm ? 2'b01 : 2'b00, 2'b00, alu, fw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_aluwb(input logic rw, input logic pcs);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 2'b00, rw, 1'b0, pcs, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_branch();
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 3'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_mulwait();
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'd5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endfunction

   // MemReady value for states where it must have no effect.
   function automatic logic rmr();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
      cur_op    = op;
      cur_funct = funct;
      cur_rd    = rd;
   endtask

   task automatic push(input string tag, input logic mr, input logic [17:0] exp);
      sb_t e;
      e.mr    = mr;
      e.op    = cur_op;
      e.funct = cur_funct;
      e.rd    = cur_rd;
      e.ismul = cur_ismul;
      e.exp   = exp;
      e.tag   = tag;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      sb_t e;
      logic [17:0] got;
      instr(2'b00, 6'b001000, 4'd1);
      push("reset_hold0", 1'b1, e_fetch(1'b0));
      push("reset_hold1", 1'b1, e_fetch(1'b0));
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(negedge clk);
         bus.MemReady = e.mr; bus.Op = e.op; bus.Funct = e.funct; bus.Rd = e.rd; bus.IsMul = e.ismul;
         #1;
         got = observed();
         n_chk++;
         if (got !== e.exp) $display("FAIL %s: got %b expected %b", e.tag, got, e.exp);
         else n_pass++;
      end
      bus.MemReady = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_dataproc();
      sb_t e;
      logic [17:0] got;
      instr(2'b00, 6'b001000, 4'd1);                 // ADD R1
      push("add_fetch", 1'b1, e_fetch(1'b1));
      push("add_decode", rmr(), e_decode(1'b0));
      push("add_execr", rmr(), e_exec(1'b0, 3'd0, 2'b00));
      push("add_aluwb", rmr(), e_aluwb(1'b1, 1'b0));
      instr(2'b00, 6'b101001, 4'd15);                // ADDS R15, imm
      push("addi_fetch", 1'b1, e_fetch(1'b1));
      push("addi_decode", rmr(), e_decode(1'b0));
      push("addi_execi", rmr(), e_exec(1'b1, 3'd0, 2'b11));
      push("addi_aluwb_pcs", rmr(), e_aluwb(1'b1, 1'b1));
      instr(2'b00, 6'b011001, 4'd3);                 // ORRS R3
      push("orr_fetch", 1'b1, e_fetch(1'b1));
      push("orr_decode", rmr(), e_decode(1'b0));
      push("orr_execr", rmr(), e_exec(1'b0, 3'd3, 2'b10));
      push("orr_aluwb", rmr(), e_aluwb(1'b1, 1'b0));
      instr(2'b00, 6'b000010, 4'd7);                 // EOR R7
      push("eor_fetch", 1'b1, e_fetch(1'b1));
      push("eor_decode", rmr(), e_decode(1'b0));
      push("eor_execr", rmr(), e_exec(1'b0, 3'd4, 2'b00));
      push("eor_aluwb", rmr(), e_aluwb(1'b1, 1'b0));
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(negedge clk);
         bus.MemReady = e.mr; bus.Op = e.op; bus.Funct = e.funct; bus.Rd = e.rd; bus.IsMul = e.ismul;
         #1;
         got = observed();
         n_chk++;
         if (got !== e.exp) $display("FAIL %s: got %b expected %b", e.tag, got, e.exp);
         else n_pass++;
      end
   endtask

   task automatic test_cmp_tst();
      sb_t e;
      logic [17:0] got;
      instr(2'b00, 6'b010101, 4'd0);                 // CMP
      push("cmp_fetch", 1'b1, e_fetch(1'b1));
      push("cmp_decode", rmr(), e_decode(1'b0));
      push("cmp_execr", rmr(), e_exec(1'b0, 3'd1, 2'b11));
      push("cmp_aluwb_nowrite", rmr(), e_aluwb(1'b0, 1'b0));
      instr(2'b00, 6'b010001, 4'd15);                // TST with Rd field 15: no PCS
      push("tst_fetch", 1'b1, e_fetch(1'b1));
      push("tst_decode", rmr(), e_decode(1'b0));
      push("tst_execr", rmr(), e_exec(1'b0, 3'd2, 2'b10));
      push("tst_aluwb_nowrite", rmr(), e_aluwb(1'b0, 1'b0));
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(negedge clk);
         bus.MemReady = e.mr; bus.Op = e.op; bus.Funct = e.funct; bus.Rd = e.rd; bus.IsMul = e.ismul;
         #1;
         got = observed();
         n_chk++;
         if (got !== e.exp) $display("FAIL %s: got %b expected %b", e.tag, got, e.exp);
         else n_pass++;
      end
   endtask

   task automatic test_memory();
      sb_t e;
      logic [17:0] got;
      instr(2'b01, 6'b011001, 4'd2);                 // LDR R2, 3-cycle memory stall
      push("ldr_fetch", 1'b1, e_fetch(1'b1));
      push("ldr_decode", rmr(), e_decode(1'b0));
      push("ldr_memadr", rmr(), e_memadr());
      for (int i = 0; i < 3; i++) push("ldr_memrd_wait", 1'b0, e_memrd());
      push("ldr_memrd_done", 1'b1, e_memrd());
      push("ldr_memwb", rmr(), e_memwb(1'b0));
      instr(2'b01, 6'b011001, 4'd15);                // LDR PC
      push("ldrpc_fetch", 1'b1, e_fetch(1'b1));
      push("ldrpc_decode", rmr(), e_decode(1'b0));
      push("ldrpc_memadr", rmr(), e_memadr());
      push("ldrpc_memrd", 1'b1, e_memrd());
      push("ldrpc_memwb_pcs", rmr(), e_memwb(1'b1));
      instr(2'b01, 6'b011000, 4'd4);                 // STR, one wait cycle
      push("str_fetch", 1'b1, e_fetch(1'b1));
      push("str_decode", rmr(), e_decode(1'b0));
      push("str_memadr", rmr(), e_memadr());
      push("str_memwr_wait", 1'b0, e_memwr());
      push("str_memwr_done", 1'b1, e_memwr());
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(negedge clk);
         bus.MemReady = e.mr; bus.Op = e.op; bus.Funct = e.funct; bus.Rd = e.rd; bus.IsMul = e.ismul;
         #1;
         got = observed();
         n_chk++;
         if (got !== e.exp) $display("FAIL %s: got %b expected %b", e.tag, got, e.exp);
         else n_pass++;
      end
   endtask

   task automatic test_branch();
      sb_t e;
      logic [17:0] got;
      instr(2'b10, 6'b100000, 4'd0);
      push("b_fetch", 1'b1, e_fetch(1'b1));
      push("b_decode", rmr(), e_decode(1'b0));
      push("b_branch", rmr(), e_branch());
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(negedge clk);
         bus.MemReady = e.mr; bus.Op = e.op; bus.Funct = e.funct; bus.Rd = e.rd; bus.IsMul = e.ismul;
         #1;
         got = observed();
         n_chk++;
         if (got !== e.exp) $display("FAIL %s: got %b expected %b", e.tag, got, e.exp);
         else n_pass++;
      end
      n_chk++;
      if ({bus.ImmSrc, bus.RegSrc} !== 4'b1010)
         $display("FAIL b_immsrc_regsrc: got %b expected 1010", {bus.ImmSrc, bus.RegSrc});
      else n_pass++;
   endtask

   task automatic test_undef();
      sb_t e;
      logic [17:0] got;
      instr(2'b11, 6'b000000, 4'd0);                 // Op 11
      push("op11_fetch", 1'b1, e_fetch(1'b1));
      push("op11_decode_undef", rmr(), e_decode(1'b1));
      instr(2'b00, 6'b011010, 4'd1);                 // cmd 1101 unsupported
      push("mov_fetch", 1'b1, e_fetch(1'b1));
      push("mov_decode_undef", rmr(), e_decode(1'b1));
      push("undef_back_fetch", 1'b0, e_fetch(1'b0));
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(negedge clk);
         bus.MemReady = e.mr; bus.Op = e.op; bus.Funct = e.funct; bus.Rd = e.rd; bus.IsMul = e.ismul;
         #1;
         got = observed();
         n_chk++;
         if (got !== e.exp) $display("FAIL %s: got %b expected %b", e.tag, got, e.exp);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      sb_t e;
      logic [17:0] got;
      instr(2'b00, 6'b000100, 4'd5);                 // SUB R5 after a fetch stall
      push("b2b_fetch_wait0", 1'b0, e_fetch(1'b0));
      push("b2b_fetch_wait1", 1'b0, e_fetch(1'b0));
      push("b2b_sub_fetch", 1'b1, e_fetch(1'b1));
      push("b2b_sub_decode", rmr(), e_decode(1'b0));
      push("b2b_sub_execr", rmr(), e_exec(1'b0, 3'd1, 2'b00));
      push("b2b_sub_aluwb", rmr(), e_aluwb(1'b1, 1'b0));
      instr(2'b10, 6'b101111, 4'd9);
      push("b2b_b_fetch", 1'b1, e_fetch(1'b1));
      push("b2b_b_decode", rmr(), e_decode(1'b0));
      push("b2b_b_branch", rmr(), e_branch());
      instr(2'b01, 6'b010000, 4'd6);
      push("b2b_str_fetch", 1'b1, e_fetch(1'b1));
      push("b2b_str_decode", rmr(), e_decode(1'b0));
      push("b2b_str_memadr", rmr(), e_memadr());
      push("b2b_str_memwr", 1'b1, e_memwr());
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(negedge clk);
         bus.MemReady = e.mr; bus.Op = e.op; bus.Funct = e.funct; bus.Rd = e.rd; bus.IsMul = e.ismul;
         #1;
         got = observed();
         n_chk++;
         if (got !== e.exp) $display("FAIL %s: got %b expected %b", e.tag, got, e.exp);
         else n_pass++;
      end
   endtask

   task automatic test_mul();
      sb_t e;
      logic [17:0] got;
      instr(2'b00, 6'b000000, 4'd5);
      cur_ismul = 1'b1;
      push("mul_fetch", 1'b1, e_fetch(1'b1));
      push("mul_decode", rmr(), e_decode(1'b0));
      push("mul_execr", rmr(), e_exec(1'b0, 3'd2, 2'b00));
`ifdef ARM_MUL_EN
      for (int i = 0; i < 4; i++) push("mul_wait", rmr(), e_mulwait());
`endif
      push("mul_aluwb", rmr(), e_aluwb(1'b1, 1'b0));
      cur_ismul = 1'b0;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(negedge clk);
         bus.MemReady = e.mr; bus.Op = e.op; bus.Funct = e.funct; bus.Rd = e.rd; bus.IsMul = e.ismul;
         #1;
         got = observed();
         n_chk++;
         if (got !== e.exp) $display("FAIL %s: got %b expected %b", e.tag, got, e.exp);
         else n_pass++;
      end
      bus.IsMul = 1'b0;
   endtask

   task automatic test_reset_mid();
      sb_t e;
      logic [17:0] got;
      instr(2'b01, 6'b011000, 4'd4);
      push("rm_fetch", 1'b1, e_fetch(1'b1));
      push("rm_decode", rmr(), e_decode(1'b0));
      push("rm_memadr", rmr(), e_memadr());
      push("rm_memwr_wait", 1'b0, e_memwr());
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(negedge clk);
         bus.MemReady = e.mr; bus.Op = e.op; bus.Funct = e.funct; bus.Rd = e.rd; bus.IsMul = e.ismul;
         #1;
         got = observed();
         n_chk++;
         if (got !== e.exp) $display("FAIL %s: got %b expected %b", e.tag, got, e.exp);
         else n_pass++;
      end
      // Abort the stalled store with reset between clock edges.
      @(negedge clk);
      bus.MemReady = 1'b1;
      reset = 1'b0;
      #1;
      n_chk++;
      if (bus.MemW !== 1'b0) $display("FAIL rm_memw_drop: got %b expected 0", bus.MemW);
      else n_pass++;
      got = observed();
      n_chk++;
      if (got !== e_fetch(1'b0)) $display("FAIL rm_reset_outputs: got %b expected %b", got, e_fetch(1'b0));
      else n_pass++;
      @(negedge clk);
      bus.MemReady = 1'b0;
      reset = 1'b1;
      push("rm_after_wait", 1'b0, e_fetch(1'b0));
      push("rm_after_fetch", 1'b1, e_fetch(1'b1));
      push("rm_after_decode", rmr(), e_decode(1'b0));
      push("rm_after_memadr", rmr(), e_memadr());
      push("rm_after_memwr", 1'b1, e_memwr());
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(negedge clk);
         bus.MemReady = e.mr; bus.Op = e.op; bus.Funct = e.funct; bus.Rd = e.rd; bus.IsMul = e.ismul;
         #1;
         got = observed();
         n_chk++;
         if (got !== e.exp) $display("FAIL %s: got %b expected %b", e.tag, got, e.exp);
         else n_pass++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b0;
      cur_ismul    = 1'b0;
      bus.MemReady = 1'b1;
      bus.Op       = 2'b00;
      bus.Funct    = 6'b001000;
      bus.Rd       = 4'd1;
      bus.IsMul    = 1'b0;
      test_reset();
      test_dataproc();
      test_cmp_tst();
      test_memory();
      test_branch();
      test_undef();
      test_back_to_back();
      test_mul();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
